// File: rtl/sram_responder.sv
// Word-addressed SRAM responder with an in-order valid/ready response buffer.
// Optional macro SRAM_RESPONDER_WRITE_ACK_EN makes every accepted WRITE produce a response.
package sram_responder_pkg;
  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    mem_type_e   mtype;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_pkt_t;
endpackage

module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int N_BITS        = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int RSP_BUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     req_vld,
  output logic     req_rdy,
  input  mem_pkt_t req,
  output logic     rsp_vld,
  input  logic     rsp_rdy,
  output mem_pkt_t rsp,
  output logic     err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (RSP_BUF_DEPTH > 1) ? $clog2(RSP_BUF_DEPTH) : 1;
  localparam int CW = $clog2(RSP_BUF_DEPTH + 1);

`ifdef SRAM_RESPONDER_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic [N_BITS-1:0] mem_q [DEPTH_WORDS];
  mem_pkt_t          buf_q [RSP_BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              accept, retire, push, do_wr;
  logic              is_b, is_h, misal;
  logic [AW-1:0]     idx;
  logic [1:0]        off;
  logic [N_BITS-1:0] word, shifted, rdata, wdata;
  logic [3:0]        mask;
  mem_pkt_t          push_pkt;
  logic              unused_addr;

  assign unused_addr = ^req.addr[31:AW+2];

  assign rsp_vld = !rst && (cnt_q != '0);
  assign retire  = rsp_vld && rsp_rdy;
  // A retire on the same edge frees the slot a full buffer needs.
  assign req_rdy = !rst && ((cnt_q < CW'(RSP_BUF_DEPTH)) || retire);
  assign accept  = req_vld && req_rdy;
  assign rsp     = rsp_vld ? buf_q[rd_ptr_q] : '0;
  assign err     = err_q && !rst;

  assign idx     = req.addr[AW+1:2];
  assign off     = req.addr[1:0];
  assign word    = mem_q[idx];
  assign shifted = word >> {off, 3'b000};
  assign is_b    = (req.len == 2'b01);
  assign is_h    = (req.len == 2'b10);

  always_comb begin
    mask  = 4'b1111;
    wdata = req.data;
    rdata = word;
    misal = 1'b0;
    unique case (1'b1)
      is_b: begin
        mask  = 4'b0001 << off;
        wdata = {4{req.data[7:0]}};
        rdata = {24'b0, shifted[7:0]};
      end
      is_h: begin
        misal = off[0];
        mask  = 4'b0011 << off;
        wdata = {2{req.data[15:0]}};
        rdata = {16'b0, shifted[15:0]};
      end
      default: misal = (off != 2'b00);
    endcase
  end

  always_comb begin
    push  = accept && ((req.mtype == MEM_READ) || WR_ACK);
    do_wr = accept && (req.mtype == MEM_WRITE) && !misal;
    err_d = accept && misal;

    push_pkt       = req;
    push_pkt.data  = '0;
    if (req.mtype == MEM_READ && !misal)
      push_pkt.data = rdata;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PW'(RSP_BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (retire)
      rd_ptr_d = (rd_ptr_q == PW'(RSP_BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage and buffer payload are not reset; enables are already low in reset.
  always_ff @(posedge clk) begin
    if (push)
      buf_q[wr_ptr_q] <= push_pkt;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_wr && mask[b])
        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table plus multi-cycle sequences.
// Expected write-response count follows SRAM_RESPONDER_WRITE_ACK_EN.
module tb_sram_responder;
  import sram_responder_pkg::*;

`ifdef SRAM_RESPONDER_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic     clk;
  logic     rst;
  logic     req_vld;
  logic     req_rdy;
  mem_pkt_t req;
  logic     rsp_vld;
  logic     rsp_rdy;
  mem_pkt_t rsp;
  logic     err;

  int checks;
  int errors;
  int wr_rsp;
  int wr_exp;

  sram_responder dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req     (req),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp     (rsp),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    bit          xerr;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [17];

  function automatic mem_pkt_t mk(bit wr, logic [31:0] a,
                                  logic [1:0] l, logic [31:0] d);
    mem_pkt_t p;
    p.mtype = wr ? MEM_WRITE : MEM_READ;
    p.addr  = a;
    p.len   = l;
    p.data  = d;
    return p;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input int n);
    mem_pkt_t e;
    string    s;
    s = $sformatf("v%0d", n);
    e = mk(v.wr, v.addr, v.len, v.wr ? 32'h0 : v.exp);
    @(negedge clk);
    req     = mk(v.wr, v.addr, v.len, v.data);
    req_vld = 1'b1;
    #1 chk({s, "_rdy"}, req_rdy, 1'b1);
    @(posedge clk);
    #1 req_vld = 1'b0;
    chk({s, "_err"}, err, v.xerr);
    chk({s, "_vld"}, rsp_vld, (!v.wr) || ACK);
    if (rsp_vld) begin
      chk({s, "_rsp"}, rsp, e);
      if (rsp.mtype == MEM_WRITE) wr_rsp++;
    end
    @(posedge clk);
    #1 chk({s, "_err_off"}, err, 1'b0);
    chk({s, "_vld_off"}, rsp_vld, 1'b0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    wr_rsp  = 0;
    wr_exp  = 0;
    rst     = 1'b1;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    req     = '0;

    tv[0]  = '{1, 32'h10,   2'b00, 32'h11223344, 0, 32'h0};
    tv[1]  = '{1, 32'h13,   2'b01, 32'h000000AA, 0, 32'h0};
    tv[2]  = '{0, 32'h10,   2'b00, 32'h0,        0, 32'hAA223344};
    tv[3]  = '{0, 32'h12,   2'b10, 32'h0,        0, 32'h0000AA22};
    tv[4]  = '{0, 32'h11,   2'b01, 32'h0,        0, 32'h00000033};
    tv[5]  = '{1, 32'h20,   2'b00, 32'hCAFEF00D, 0, 32'h0};
    tv[6]  = '{0, 32'h21,   2'b10, 32'h0,        1, 32'h0};
    tv[7]  = '{0, 32'h20,   2'b00, 32'h0,        0, 32'hCAFEF00D};
    tv[8]  = '{1, 32'h22,   2'b10, 32'hFFFF1234, 0, 32'h0};
    tv[9]  = '{0, 32'h20,   2'b00, 32'h0,        0, 32'h1234F00D};
    tv[10] = '{1, 32'h22,   2'b00, 32'h55555555, 1, 32'h0};
    tv[11] = '{0, 32'h20,   2'b00, 32'h0,        0, 32'h1234F00D};
    tv[12] = '{0, 32'h20,   2'b11, 32'h0,        0, 32'h1234F00D};
    tv[13] = '{1, 32'h20,   2'b01, 32'h00000777, 0, 32'h0};
    tv[14] = '{0, 32'h20,   2'b10, 32'h0,        0, 32'h0000F077};
    tv[15] = '{1, 32'h10 + 4*1024, 2'b00, 32'h0BADCAFE, 0, 32'h0};
    tv[16] = '{0, 32'h10,   2'b00, 32'h0,        0, 32'h0BADCAFE};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", req_rdy, 1'b0);
    chk("rst_vld", rsp_vld, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    #1 chk("post_rst_rdy", req_rdy, 1'b1);

    // write then read next cycle
    @(negedge clk);
    req     = mk(1, 32'h10, 2'b00, 32'hDEADBEEF);
    req_vld = 1'b1;
    @(posedge clk);
    #1 req  = mk(0, 32'h10, 2'b00, 32'h0);
    wr_exp++;
    chk("b2b_wvld", rsp_vld, ACK);
    if (rsp_vld && rsp.mtype == MEM_WRITE) wr_rsp++;
    @(posedge clk);
    #1 req_vld = 1'b0;
    chk("b2b_rvld", rsp_vld, 1'b1);
    chk("b2b_rsp", rsp, mk(0, 32'h10, 2'b00, 32'hDEADBEEF));
    @(posedge clk);
    #1 chk("b2b_idle", rsp_vld, 1'b0);

    for (int i = 0; i < 17; i++) begin
      if (tv[i].wr) wr_exp++;
      do_req(tv[i], i);
    end

    // buffer full backpressure, third accepted on first retire
    rsp_rdy = 1'b0;
    @(negedge clk);
    req     = mk(0, 32'h10, 2'b00, 32'h0);
    req_vld = 1'b1;
    @(posedge clk);
    #1 req  = mk(0, 32'h20, 2'b00, 32'h0);
    @(negedge clk);
    chk("bp_rdy1", req_rdy, 1'b1);
    @(posedge clk);
    #1 req  = mk(0, 32'h12, 2'b10, 32'h0);
    @(negedge clk);
    chk("bp_full", req_rdy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_rdy", req_rdy, 1'b0);
    chk("bp_hold_rsp", rsp, mk(0, 32'h10, 2'b00, 32'h0BADCAFE));
    rsp_rdy = 1'b1;
    #1 chk("bp_rdy_retire", req_rdy, 1'b1);
    @(posedge clk);
    #1 req_vld = 1'b0;
    chk("bp_rsp2", rsp, mk(0, 32'h20, 2'b00, 32'h1234F077));
    @(posedge clk);
    #1 chk("bp_rsp3", rsp, mk(0, 32'h12, 2'b10, 32'h00000BAD));
    @(posedge clk);
    #1 chk("bp_empty", rsp_vld, 1'b0);

    // reset with two buffered responses and a write offered
    rsp_rdy = 1'b0;
    @(negedge clk);
    req     = mk(0, 32'h10, 2'b00, 32'h0);
    req_vld = 1'b1;
    @(posedge clk);
    #1 req  = mk(0, 32'h20, 2'b00, 32'h0);
    @(posedge clk);
    #1 req_vld = 1'b0;
    @(negedge clk);
    chk("rs_pre_vld", rsp_vld, 1'b1);
    rst     = 1'b1;
    req     = mk(1, 32'h20, 2'b00, 32'hFFFFFFFF);
    req_vld = 1'b1;
    #1 chk("rs_vld", rsp_vld, 1'b0);
    chk("rs_rdy", req_rdy, 1'b0);
    chk("rs_rsp", rsp, '0);
    @(posedge clk);
    #1 chk("rs_vld2", rsp_vld, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    req_vld = 1'b0;
    #1 chk("rs_rel_rdy", req_rdy, 1'b1);
    chk("rs_rel_vld", rsp_vld, 1'b0);
    @(posedge clk);
    #1 chk("rs_stale", rsp_vld, 1'b0);
    rsp_rdy = 1'b1;
    do_req('{0, 32'h20, 2'b00, 32'h0, 0, 32'h1234F077}, 100);
    do_req('{0, 32'h10, 2'b00, 32'h0, 0, 32'h0BADCAFE}, 101);

    chk("wr_rsp_cnt", wr_rsp, ACK ? wr_exp : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
